// File: rtl/exhaustive_checker.sv
// Exhaustive stimulus engine: sweeps every N-bit input vector into a DUT,
// samples its output after a settle window and checks it against EXPECT.
module exhaustive_checker #(
   parameter int                N      = 3,
   parameter logic [(1<<N)-1:0] EXPECT = 8'b1110_1000,
   parameter int                SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         dut_out,
   output logic [N-1:0] dut_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic [N-1:0] first_fail,
   output logic         first_fail_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state, state_nx;
   logic [N-1:0] vec;
   logic [3:0]   cnt;
   logic         launch, sample, mismatch, last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      sample   = 1'b0;
      mismatch = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: a sweep runs to completion
            sample   = (cnt == 4'(SETTLE));
            mismatch = sample && (dut_out != EXPECT[vec]);
            last     = sample && (vec == {N{1'b1}});
            if (last) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec              <= '0;
         cnt              <= '0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
      end else if (launch) begin
         vec              <= '0;
         cnt              <= '0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
      end else if (state == RUN) begin
         if (!sample) begin
            cnt <= cnt + 4'd1;
         end else begin
            cnt <= '0;
            if (mismatch) begin
               err_count <= err_count + (N+1)'(1);
               if (!first_fail_valid) begin
                  first_fail       <= vec;
                  first_fail_valid <= 1'b1;
               end
            end
            // pass must fold in the last vector's result, not yet in err_count
            if (last) pass <= !mismatch && (err_count == '0);
            else      vec  <= vec + N'(1);
         end
      end
   end

   assign dut_in = vec;
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

endmodule

// File: tb/tb_exhaustive_checker.sv
// Bench for exhaustive_checker: directed and randomized DUT truth tables,
// checked against a simple vector-by-vector reference model.
module tb_exhaustive_checker;

   localparam logic [7:0] MAJ = 8'b1110_1000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   failed = 0;

   // N=3, SETTLE=1 instance
   logic       start3 = 1'b0;
   logic [7:0] tbl = MAJ;
   logic       dut_out3;
   logic [2:0] dut_in3, ff3;
   logic [3:0] err3;
   logic       busy3, done3, pass3, ffv3;

   // N=1, SETTLE=0 instance
   logic       start1 = 1'b0;
   logic       dut_out1;
   logic [0:0] dut_in1, ff1;
   logic [1:0] err1;
   logic       busy1, done1, pass1, ffv1;

   always #5 clk = ~clk;

   assign dut_out3 = tbl[dut_in3];
   assign dut_out1 = dut_in1[0];

   exhaustive_checker #(.N(3), .EXPECT(MAJ), .SETTLE(1)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .dut_out(dut_out3),
      .dut_in(dut_in3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .first_fail(ff3), .first_fail_valid(ffv3));

   exhaustive_checker #(.N(1), .EXPECT(2'b10), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .dut_out(dut_out1),
      .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One full sweep on the N=3 instance; pulse_at >= 0 asserts start
   // for one cycle at that cycle offset inside the sweep.
   task automatic sweep(input logic [7:0] t, input int pulse_at);
      int exp_err = 0;
      int exp_ff  = 0;
      bit found   = 0;
      for (int v = 0; v < 8; v++)
         if (t[v] != MAJ[v]) begin
            exp_err++;
            if (!found) begin
               exp_ff = v;
               found  = 1;
            end
         end
      tbl    = t;
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      chk("clr_err", err3, 0);
      chk("clr_ffv", ffv3, 0);
      chk("clr_done", done3, 0);
      chk("clr_pass", pass3, 0);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         start3 = (pulse_at >= 0 && k == pulse_at);
         chk("busy", busy3, 1);
         chk("dut_in", dut_in3, k / 2);
      end
      @(negedge clk);
      start3 = 1'b0;
      chk("end_busy", busy3, 0);
      chk("end_done", done3, 1);
      chk("end_dut_in", dut_in3, 7);
      chk("pass", pass3, exp_err == 0);
      chk("err_count", err3, exp_err);
      chk("first_fail_valid", ffv3, found);
      chk("first_fail", ff3, exp_ff);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_dut_in", dut_in3, 0);
      chk("rst_busy", busy3, 0);
      chk("rst_done", done3, 0);
      chk("rst_pass", pass3, 0);
      chk("rst_err", err3, 0);
      chk("rst_ff", ff3, 0);
      chk("rst_ffv", ffv3, 0);

      sweep(MAJ, -1);          // correct majority DUT
      sweep(8'h00, -1);        // stuck at 0
      sweep(~MAJ, -1);         // inverted
      sweep(MAJ, 4);           // start at vector 2 is ignored, restart after failing run
      for (int r = 0; r < 4; r++)
         sweep(8'($urandom), ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1);

      // reset mid-sweep at vector 4
      tbl    = MAJ;
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_rst_vec", dut_in3, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_dut_in", dut_in3, 0);
      chk("mid_rst_busy", busy3, 0);
      chk("mid_rst_done", done3, 0);
      chk("mid_rst_pass", pass3, 0);
      chk("mid_rst_err", err3, 0);
      chk("mid_rst_ff", ff3, 0);
      chk("mid_rst_ffv", ffv3, 0);
      repeat (20) @(negedge clk);
      chk("post_rst_done", done3, 0);
      chk("post_rst_busy", busy3, 0);

      // N=1, SETTLE=0 with a buffer DUT
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("n1_busy0", busy1, 1);
      chk("n1_in0", dut_in1, 0);
      @(negedge clk);
      chk("n1_busy1", busy1, 1);
      chk("n1_in1", dut_in1, 1);
      chk("n1_done_early", done1, 0);
      @(negedge clk);
      chk("n1_done", done1, 1);
      chk("n1_busy_end", busy1, 0);
      chk("n1_pass", pass1, 1);
      chk("n1_err", err1, 0);
      chk("n1_ffv", ffv1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/exhaustive_checker.md
# exhaustive_checker

Self-checking exhaustive stimulus engine for small combinational blocks. It replaces hand-written fixed-vector benches with a parametrised sequencer. On `start` it drives every input combination 0 … 2^N−1 to a DUT. It waits a programmable settle time per vector, then samples the DUT's single output and compares it against a truth table given as a parameter. It counts mismatches, records the first failing vector, and reports pass/fail. It is synthesisable, so the same block can run in simulation benches and on the lab board.

## Interface
Parameters:
- `N`, 3: DUT input width. Legal range 1–8.
- `EXPECT`, 8'b1110_1000: expected truth table, width 2^N. Bit v is the expected DUT output for input vector v.
- `SETTLE`, 1: number of extra cycles each vector is held before sampling. Legal range 0–15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begins a sweep. Sampled only in IDLE or DONE.
- `dut_out`  in  1: DUT output under test.
- `dut_in`  out  N: vector currently driven to the DUT.
- `busy`  out  1: high while sweeping.
- `done`  out  1: high in DONE and held until the next start or reset.
- `pass`  out  1: valid when `done`=1. Equal to (`err_count`==0).
- `err_count`  out  N+1: number of mismatching vectors. Maximum value 2^N; no saturation is needed.
- `first_fail`  out  N: lowest vector that mismatched.
- `first_fail_valid`  out  1: set when `first_fail` holds a captured vector.

## Operation
- States:
  - IDLE: reset state.
  - RUN: sweeping vectors.
  - DONE: sweep complete, results held.
- Internal registers:
  - vector counter `vec` (N bits), which drives `dut_in` directly.
  - settle counter `cnt` (4 bits).
- IDLE → RUN on `start`=1. On that transition:
  - `vec`←0, `cnt`←0.
  - `err_count`←0, `first_fail`←0, `first_fail_valid`←0.
  - `pass`←0, `done`←0.
- In RUN, while `cnt`≠SETTLE: `cnt` increments and `vec` holds.
- In RUN, on the edge where `cnt`==SETTLE (the sample edge):
  - Compare `dut_out` with `EXPECT[vec]`.
  - On mismatch, `err_count` increments.
  - On a mismatch while `first_fail_valid`=0, capture `first_fail`←`vec` and set `first_fail_valid`←1.
  - `cnt`←0.
  - If `vec`==2^N−1, go to DONE. Otherwise `vec` increments.
- Entering DONE: `done`←1, `busy`←0, and `pass`←(final error count == 0). The comparison includes the last vector's result.
- DONE → RUN on `start`=1, with the same clearing as leaving IDLE.
- `start` while in RUN is ignored. The sweep is neither restarted nor extended.
- `rst`=1 overrides everything on any edge, including mid-sweep. Result: state IDLE and all outputs 0.
- `dut_in` holds its last value (2^N−1) in DONE. It returns to 0 only on a restart or reset.

## Timing
- Reset values:
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `first_fail`=0, `first_fail_valid`=0.
- `start` is sampled at edge E. From E+ onward, `busy`=1 and `dut_in`=0.
- Each vector is held for SETTLE+1 cycles. `dut_out` is sampled on the last edge of the vector's window.
  - Result: the DUT has SETTLE+1 full cycles of combinational settling from the `dut_in` change.
- `busy` stays high for exactly 2^N·(SETTLE+1) cycles.
- `done` rises at edge E + 2^N·(SETTLE+1), in the same cycle that `busy` falls.
- `err_count` and `first_fail*` update on the sample edge and are visible the following cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- With SETTLE=0, one vector per cycle. `dut_out` must then settle within one cycle of the registered `dut_in`.

## Test plan
- Use N=3, EXPECT=8'b1110_1000, SETTLE=1. Drive a correct majority DUT and pulse `start`.
  - Required: `busy` high for 16 cycles.
  - Required: `dut_in` steps 0…7, each value held 2 cycles.
  - Required: `done`=1, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- Same config, with the DUT output stuck at 0.
  - Required: `err_count`=4, `first_fail`=3, `first_fail_valid`=1, `pass`=0.
- Same config, with the DUT output inverted.
  - Required: `err_count`=8, `first_fail`=0, `pass`=0.
- Assert `rst` for one cycle at vector 4, mid-sweep.
  - Required on the next cycle: state IDLE, every output 0, and no `done`.
- Pulse `start` at vector 2 during RUN.
  - Required: ignored; the sweep completes at the original cycle count.
- Pulse `start` in DONE after a failing run, then run with a correct DUT.
  - Required: counters are cleared at the restart and the run ends with `pass`=1.
- Use N=1, EXPECT=2'b10, SETTLE=0 with a buffer DUT.
  - Required: `done` 2 cycles after `start` and `pass`=1.
